// File: rtl/uart_tx_arbiter_if.sv
// Byte-channel bundle shared by the requesters, the arbiter and uart_tx.
// The arbiter takes the slave view; whoever drives the requesters and uart_tx takes the master view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               timeout_pulse;

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, busy, timeout_pulse
    );

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, busy, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of uart_tx: one owner holds the byte channel until its
// req_last byte is accepted, or until the watchdog sees it idle for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] lastOwner_q;
    logic [TMR_W-1:0] timer_q;
    logic [N_REQ-1:0] grant_q;
    logic             busy_q;
    logic             timeoutPulse_q;

    logic             ownerFound;
    logic [IDX_W-1:0] owner_d;
    logic             ownerValid;
    logic             ownerLast;
    logic [7:0]       ownerData;
    logic             accept;

    // Requesters above the last owner take priority over those at or below it, lowest index first.
    always_comb begin
        logic             hiFound;
        logic             loFound;
        logic [IDX_W-1:0] hiIdx;
        logic [IDX_W-1:0] loIdx;
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (IDX_W'(i) > lastOwner_q) begin
                    hiFound = 1'b1;
                    hiIdx   = IDX_W'(i);
                end else begin
                    loFound = 1'b1;
                    loIdx   = IDX_W'(i);
                end
            end
        end
        ownerFound = hiFound | loFound;
        owner_d    = hiFound ? hiIdx : loIdx;
    end

    assign ownerValid = bus.req_valid[owner_q];
    assign ownerLast  = bus.req_last[owner_q];
    assign ownerData  = bus.req_data[{owner_q, 3'b000} +: 8];
    assign accept     = busy_q & ownerValid & bus.tx_ready;

    // grant_q is zero outside LOCKED, so it also masks the ready path while idle.
    assign bus.tx_valid      = busy_q & ownerValid;
    assign bus.tx_data       = busy_q ? ownerData : 8'h00;
    assign bus.req_ready     = bus.tx_ready ? grant_q : '0;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_pulse = timeoutPulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            lastOwner_q    <= IDX_W'(N_REQ - 1);
            timer_q        <= '0;
            grant_q        <= '0;
            busy_q         <= 1'b0;
            timeoutPulse_q <= 1'b0;
        end else begin
            timeoutPulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ownerFound) begin
                        state_q <= LOCKED;
                        owner_q <= owner_d;
                        grant_q <= N_REQ'(1) << owner_d;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        timer_q <= '0;
                        if (ownerLast) begin
                            state_q     <= IDLE;
                            lastOwner_q <= owner_q;
                            grant_q     <= '0;
                            busy_q      <= 1'b0;
                        end
                    end else if (!ownerValid) begin
                        // A valid owner waiting on a busy UART is not stalled, so only idle cycles count.
                        if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                            state_q        <= IDLE;
                            lastOwner_q    <= owner_q;
                            grant_q        <= '0;
                            busy_q         <= 1'b0;
                            timer_q        <= '0;
                            timeoutPulse_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
